// File: rtl/prod_bcd_conv_pkg.sv
// ---------------------------------------------------------------------------
// prod_bcd_conv_pkg
// Shared definitions for the product-to-BCD converter: FSM state encoding,
// the double-dabble add-3 threshold and the per-digit correction helper.
// ---------------------------------------------------------------------------
package prod_bcd_conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic [3:0] BCD_ADD3_THRESH = 4'd5;

    // Double-dabble correction: a digit of 5..9 would become >=10 after the
    // shift, so pre-add 3 to make the carry land in the next digit.
    function automatic logic [3:0] bcd_add3(input logic [3:0] digit);
        return (digit >= BCD_ADD3_THRESH) ? digit + 4'd3 : digit;
    endfunction

endpackage

// File: rtl/prod_bcd_conv_seg7_decode.sv
// ---------------------------------------------------------------------------
// seg7_decode
// 4-bit BCD digit to active-low 7-segment pattern, bit 0 = segment a.
// Codes above 9 produce a blank display (all segments off).
// Ports:
//   bcd    in   4  BCD digit
//   seg_n  out  7  active-low segments a..g
// ---------------------------------------------------------------------------
module seg7_decode (
    input  logic [3:0] bcd,
    output logic [6:0] seg_n
);

    always_comb begin
        case (bcd)
            4'd0:    seg_n = 7'h40;
            4'd1:    seg_n = 7'h79;
            4'd2:    seg_n = 7'h24;
            4'd3:    seg_n = 7'h30;
            4'd4:    seg_n = 7'h19;
            4'd5:    seg_n = 7'h12;
            4'd6:    seg_n = 7'h02;
            4'd7:    seg_n = 7'h78;
            4'd8:    seg_n = 7'h00;
            4'd9:    seg_n = 7'h10;
            default: seg_n = 7'h7F;
        endcase
    end

endmodule

// File: rtl/prod_bcd_conv.sv
// ---------------------------------------------------------------------------
// prod_bcd_conv
// Converts the unsigned multiplier product to packed BCD with a sequential
// double-dabble (one shift per cycle) and presents it on a valid/ready port.
// One conversion at a time; in_ready is low while converting or holding.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   ena          stage enable (0 = all state held, in_ready forced low)
//   in_valid/in_ready/in_data     input handshake, IN_W-bit product
//   out_valid/out_ready/out_bcd   output handshake, 4*DIGITS-bit packed BCD
//   seg_n, dig_sel               (BCD_SEG_EN only) multiplexed 7-seg drive
//
// Optional feature macro: BCD_SEG_EN adds the digit-scan display outputs.
// ---------------------------------------------------------------------------
module prod_bcd_conv
    import prod_bcd_conv_pkg::*;
#(
    parameter int IN_W   = 8,
    parameter int DIGITS = 3,
    parameter int SCAN_W = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_W-1:0]       in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd
`ifdef BCD_SEG_EN
    ,
    output logic [6:0]            seg_n,
    output logic [DIGITS-1:0]     dig_sel
`endif
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int DD_W  = BCD_W + IN_W;
    localparam int CNT_W = $clog2(IN_W + 1);

    generate
        if (10 ** DIGITS <= 2 ** IN_W - 1) begin : g_digits_check
            $error("prod_bcd_conv: DIGITS too small for IN_W");
        end
        if (SCAN_W < 1) begin : g_scan_check
            $error("prod_bcd_conv: SCAN_W must be at least 1");
        end
    endgenerate

    state_e             state_q, state_d;
    // {scratch BCD digits, binary shift register} as one register, so the
    // whole double-dabble step is a single left shift.
    logic [DD_W-1:0]    dd_q, dd_d, dd_adj;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [BCD_W-1:0]   out_bcd_q, out_bcd_d;
    // Holds in_ready low through reset and until the first edge after release.
    logic               ready_en_q, ready_en_d;

    assign in_ready   = ena && ready_en_q && (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);
    assign out_bcd    = out_bcd_q;
    assign ready_en_d = 1'b1;

    // NOTE: every variable gets a default at the top of always_comb; a path
    // that leaves one unassigned would infer a latch.
    always_comb begin
        state_d   = state_q;
        dd_d      = dd_q;
        count_d   = count_q;
        out_bcd_d = out_bcd_q;
        dd_adj    = dd_q;
        for (int i = 0; i < DIGITS; i++) begin
            dd_adj[IN_W + 4*i +: 4] = bcd_add3(dd_q[IN_W + 4*i +: 4]);
        end

        if (ena) begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        dd_d    = {{BCD_W{1'b0}}, in_data};
                        count_d = '0;
                        state_d = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    dd_d    = dd_adj << 1;
                    count_d = count_q + CNT_W'(1);
                    if (count_q == CNT_W'(IN_W - 1)) begin
                        state_d   = ST_DONE;
                        out_bcd_d = dd_d[DD_W-1 -: BCD_W];
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            dd_q       <= '0;
            count_q    <= '0;
            out_bcd_q  <= '0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dd_q       <= dd_d;
            count_q    <= count_d;
            out_bcd_q  <= out_bcd_d;
            ready_en_q <= ready_en_d;
        end
    end

`ifdef BCD_SEG_EN
    logic [SCAN_W-1:0] scan_q, scan_d;
    logic [DIGITS-1:0] dig_sel_q, dig_sel_d;
    logic [6:0]        seg_n_q, seg_n_d;
    logic [3:0]        sel_digit;

    // Free-running scan: advance to the next digit each time the counter
    // wraps. Segment data is looked up for the digit being selected so the
    // registered seg_n and dig_sel always change together.
    always_comb begin
        scan_d    = scan_q + SCAN_W'(1);
        dig_sel_d = dig_sel_q;
        if (&scan_q) begin
            dig_sel_d = {dig_sel_q[DIGITS-2:0], dig_sel_q[DIGITS-1]};
        end
        sel_digit = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (dig_sel_d[i]) begin
                sel_digit = out_bcd_q[4*i +: 4];
            end
        end
    end

    seg7_decode u_seg7_decode (
        .bcd   (sel_digit),
        .seg_n (seg_n_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_q    <= '0;
            dig_sel_q <= DIGITS'(1);
            seg_n_q   <= 7'h7F;
        end else begin
            scan_q    <= scan_d;
            dig_sel_q <= dig_sel_d;
            seg_n_q   <= seg_n_d;
        end
    end

    assign seg_n   = seg_n_q;
    assign dig_sel = dig_sel_q;
`endif

endmodule

// File: tb/tb_prod_bcd_conv.sv
// ---------------------------------------------------------------------------
// tb_prod_bcd_conv
// Directed bench for prod_bcd_conv: a table of products with hand-computed
// BCD results, plus sequences for back-to-back, back-pressure, mid-conversion
// reset and enable stall. Display scan is checked when BCD_SEG_EN is defined.
// ---------------------------------------------------------------------------
module tb_prod_bcd_conv;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_bcd;
`ifdef BCD_SEG_EN
    logic [6:0]  seg_n;
    logic [2:0]  dig_sel;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    prod_bcd_conv #(
        .IN_W   (8),
        .DIGITS (3)
`ifdef BCD_SEG_EN
        ,
        .SCAN_W (2)
`endif
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd)
`ifdef BCD_SEG_EN
        ,
        .seg_n     (seg_n),
        .dig_sel   (dig_sel)
`endif
    );

    typedef struct {
        logic [7:0]  din;
        logic [11:0] bcd;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles from the accept edge until out_valid, optionally dropping
    // ena for stall_len cycles starting stall_from cycles after accept.
    task automatic wait_done(input int stall_from, input int stall_len, output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            ena = !(lat >= stall_from && lat < stall_from + stall_len);
            tick();
            lat++;
        end
        ena = 1'b1;
    endtask

    task automatic convert(input string name, input logic [7:0] din, input logic [11:0] exp,
                           input int stall_from, input int stall_len, input int exp_lat);
        int lat;
        check({name, " in_ready before accept"}, in_ready, 1);
        in_valid = 1'b1;
        in_data  = din;
        tick();
        in_valid = 1'b0;
        wait_done(stall_from, stall_len, lat);
        check({name, " latency"}, lat, exp_lat);
        check({name, " out_bcd"}, out_bcd, exp);
        check({name, " in_ready in DONE"}, in_ready, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({name, " out_valid after accept"}, out_valid, 0);
        check({name, " in_ready after accept"}, in_ready, 1);
        check({name, " out_bcd kept"}, out_bcd, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'd255, 12'h255};
        vecs[1] = '{8'd0,   12'h000};
        vecs[2] = '{8'd99,  12'h099};
        vecs[3] = '{8'd144, 12'h144};
        vecs[4] = '{8'd200, 12'h200};
        vecs[5] = '{8'd1,   12'h001};
        vecs[6] = '{8'd10,  12'h010};
        vecs[7] = '{8'd128, 12'h128};
        vecs[8] = '{8'd9,   12'h009};

        rst_n     = 1'b0;
        ena       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        out_ready = 1'b0;
        tick();
        tick();
        check("reset in_ready", in_ready, 0);
        check("reset out_valid", out_valid, 0);
        check("reset out_bcd", out_bcd, 0);
`ifdef BCD_SEG_EN
        check("reset dig_sel", dig_sel, 3'b001);
        check("reset seg_n", seg_n, 7'h7F);
`endif
        rst_n = 1'b1;
        tick();
        check("first cycle after reset in_ready", in_ready, 1);

        // Table-driven conversions, 8-cycle latency each.
        for (int i = 0; i < 9; i++) begin
            convert($sformatf("vec%0d", i), vecs[i].din, vecs[i].bcd, 0, 0, 8);
        end

        // Back-to-back 0 then 99 with out_ready and in_valid held high.
        in_valid  = 1'b1;
        in_data   = 8'd0;
        out_ready = 1'b1;
        tick();
        in_data = 8'd99;
        for (int c = 0; c < 8; c++) begin
            check($sformatf("b2b in_ready shift%0d", c), in_ready, 0);
            tick();
        end
        check("b2b first out_valid", out_valid, 1);
        check("b2b first out_bcd", out_bcd, 12'h000);
        check("b2b in_ready in DONE", in_ready, 0);
        tick();
        check("b2b in_ready back in IDLE", in_ready, 1);
        tick();
        in_valid = 1'b0;
        begin
            int lat;
            wait_done(0, 0, lat);
            check("b2b second latency", lat, 8);
        end
        check("b2b second out_bcd", out_bcd, 12'h099);
        tick();
        out_ready = 1'b0;
        check("b2b second accepted", out_valid, 0);

        // Back-pressure: hold 144 in DONE for 20 cycles while in_valid is asserted.
        in_valid = 1'b1;
        in_data  = 8'd144;
        tick();
        in_data = 8'd77;
        begin
            int lat;
            wait_done(0, 0, lat);
            check("hold latency", lat, 8);
        end
        for (int c = 0; c < 20; c++) begin
            tick();
            check($sformatf("hold out_valid c%0d", c), out_valid, 1);
            check($sformatf("hold out_bcd c%0d", c), out_bcd, 12'h144);
            check($sformatf("hold in_ready c%0d", c), in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("hold accepted out_valid", out_valid, 0);
        check("hold accepted in_ready", in_ready, 1);
        tick();
        check("hold no stray conversion", out_valid, 0);
        check("hold stray in_ready", in_ready, 1);
        check("hold out_bcd kept", out_bcd, 12'h144);

        // Reset pulsed four shifts into converting 200.
        in_valid = 1'b1;
        in_data  = 8'd200;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        check("midreset out_valid", out_valid, 0);
        check("midreset out_bcd", out_bcd, 0);
        check("midreset in_ready", in_ready, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("postreset in_ready", in_ready, 1);
        check("postreset out_valid", out_valid, 0);
        convert("reapply200", 8'd200, 12'h200, 0, 0, 8);

        // Enable dropped for 5 cycles mid-conversion of 63.
        convert("stall63", 8'd63, 12'h063, 2, 5, 13);

`ifdef BCD_SEG_EN
        // Scan display of 150: digits 0,5,1 on dig_sel 001,010,100.
        convert("seg150", 8'd150, 12'h150, 0, 0, 8);
        begin
            logic [2:0] prev_sel;
            int         changes;
            logic [6:0] exp_seg;
            changes  = 0;
            prev_sel = dig_sel;
            for (int c = 0; c < 12; c++) begin
                tick();
                case (dig_sel)
                    3'b001:  exp_seg = 7'h40;
                    3'b010:  exp_seg = 7'h12;
                    3'b100:  exp_seg = 7'h79;
                    default: exp_seg = 7'h7F;
                endcase
                check($sformatf("seg onehot c%0d", c), $onehot(dig_sel), 1);
                check($sformatf("seg code c%0d", c), seg_n, exp_seg);
                if (dig_sel != prev_sel) changes++;
                prev_sel = dig_sel;
            end
            check("seg scan changes in 12 cycles", changes, 3);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
